// File: rtl/shift_reg_frame.sv
// Bidirectional serial/parallel framing shift register.
// Serial bits in become parallel frames on pdout; loaded words leave on q.
module shift_reg_frame #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic             load,
    input  logic [WIDTH-1:0] pdin,
    output logic             q,
    output logic [WIDTH-1:0] pdout,
    output logic             pvalid,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] pdout_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pvalid_reg;

    // Bit order only changes which end of sr is fed and which end drives q.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign sr_shift = {sr_reg[WIDTH-2:0], d};
            assign q        = sr_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign sr_shift = {d, sr_reg[WIDTH-1:1]};
            assign q        = sr_reg[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg     <= '0;
            pdout_reg  <= '0;
            cnt_reg    <= '0;
            pvalid_reg <= 1'b0;
        end else if (load) begin
            sr_reg     <= pdin;
            cnt_reg    <= '0;
            pvalid_reg <= 1'b0;
        end else if (en) begin
            sr_reg <= sr_shift;
            if (cnt_reg == CNT_LAST) begin
                // Publish the frame including the bit sampled on this edge.
                cnt_reg    <= '0;
                pdout_reg  <= sr_shift;
                pvalid_reg <= 1'b1;
            end else begin
                cnt_reg    <= cnt_reg + CNT_W'(1);
                pvalid_reg <= 1'b0;
            end
        end else begin
            pvalid_reg <= 1'b0;
        end
    end

    assign pdout  = pdout_reg;
    assign pvalid = pvalid_reg;
    assign cnt    = cnt_reg;

endmodule

// File: doc/shift_reg_frame.md
Name: shift_reg_frame

Overview:
- Parametrised successor to the single-bit shift_reg.
- Bidirectional serial/parallel converter: serial-in/parallel-out framing plus parallel-load/serial-out.
- Selectable bit order.
- Used at the FFT sample interface: deserialises incoming sample bitstreams into words and serialises result words out.

Parameters:
- WIDTH, 8: word/frame length in bits; legal range 2..64.
- MSB_FIRST, 1: bit order. 1 = first serial bit lands in / leaves from bit WIDTH-1. 0 = LSB first.
- CNT_W, $clog2(WIDTH): bit-counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  shift enable; one bit in and one bit out per cycle while high.
- d  input  1  serial data in.
- load  input  1  parallel load strobe.
- pdin  input  WIDTH  parallel word to load.
- q  output  1  serial data out; combinational from sr.
- pdout  output  WIDTH  last completed received frame; registered.
- pvalid  output  1  one-cycle pulse: pdout just updated.
- cnt  output  CNT_W  bits shifted in the current frame, 0..WIDTH-1.

Behaviour:
- Reset (rst=1, asynchronous): sr=0, pdout=0, pvalid=0, cnt=0, so q=0. Holds while rst is high. A frame in progress when reset hits is discarded; no pvalid is generated for it.
- Priority each cycle: rst > load > en > hold.
- load=1:
  - sr<=pdin, cnt<=0, pvalid<=0, pdout unchanged.
  - en is ignored that cycle; no shift occurs.
- en=1, load=0, MSB_FIRST=1: sr<={sr[WIDTH-2:0],d}; q=sr[WIDTH-1].
- en=1, load=0, MSB_FIRST=0: sr<={d,sr[WIDTH-1:1]}; q=sr[0].
- cnt while en=1, load=0:
  - cnt<cnt+1 while cnt<WIDTH-1.
  - cnt==WIDTH-1: cnt<=0 (wrap), pdout<=next sr value (including this cycle's d), pvalid<=1.
- pdout and pvalid become visible on the same edge, one clock after the last bit is sampled.
- pvalid is high for exactly one cycle. Back-to-back frames give pvalid once every WIDTH enabled cycles, with no dead cycle between frames.
- en=0, load=0: sr, cnt, pdout held; pvalid<=0.
  - Gaps in en stretch a frame but do not break it; the count resumes where it left off.
- Loaded words serialise on q starting the cycle after load, while new bits shift in behind them. The same sr serves simultaneous receive and transmit.
- After WIDTH enabled cycles following a load, a pvalid is produced. pdout then holds the received bits, not pdin.
- No overflow condition exists: pdout is overwritten each frame. Consumers must take it on pvalid.
- Widths are exact; no arithmetic beyond the cnt increment. cnt never reaches WIDTH.

Test Plan:
- Frame receive, MSB first: WIDTH=8, MSB_FIRST=1, rst pulse, en=1, d = 1,0,1,0,1,0,1,1 on 8 edges -> pvalid=1 for one cycle after the 8th edge, pdout=8'hAB, cnt back to 0.
- Frame receive, LSB first: same stream with MSB_FIRST=0 -> pdout=8'hD5, single pvalid pulse.
- Serial transmit: load=1 with pdin=8'h5A, then en=1 for 8 cycles -> q sequence 0,1,0,1,1,0,1,0. With MSB_FIRST=0 -> q sequence 0,1,0,1,1,0,1,0 reversed order = 0,1,0,1,1,0,1,0 read from bit0 = 0,1,0,1,1,0,1,0.
- Gapped enable: 8'hAB stream with en low for 3 cycles after bit 4 -> cnt holds at 4, no pvalid until the 8th enabled bit, pdout=8'hAB.
- Load mid-frame: after 3 bits shifted, assert load together with en=1 -> cnt=0, sr=pdin, no shift that cycle, no pvalid for 8 further enabled cycles.
- Reset mid-frame: assert rst asynchronously between edges at cnt=5 -> pdout, pvalid, cnt and q go to 0 immediately. Continuous 16-bit stream 8'hAB,8'h3C afterwards -> two pvalid pulses 8 cycles apart with pdout 8'hAB then 8'h3C.
